// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared state encoding and default sizing for period_meter
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MEAS,
    TMO
  } pm_state_e;

  localparam int PM_CNT_W   = 26;
  localparam int PM_MAX_CNT = (1 << PM_CNT_W) - 1;

endpackage

// File: rtl/period_meter_sync_rise.sv
// rtl/period_meter_sync_rise.sv - two-flop synchroniser plus history flop, rising-edge detect
module sync_rise (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic level_o,
  output logic rise_o
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_i;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level_o = s2;
  assign rise_o  = s2 & ~s3;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - period/high-time meter for a slow square wave with loss-of-signal timeout
// Optional duty measurement: define PERIOD_METER_DUTY_EN to implement hcnt and drive high_o.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W   = PM_CNT_W,
  parameter int MAX_CNT = PM_MAX_CNT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sig_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);

  logic level;
  logic rise;

  sync_rise u_sync_rise (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .sig_i  (sig_i),
    .level_o(level),
    .rise_o (rise)
  );

  pm_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             at_max;

  assign at_max  = (cnt_q == MAX_V);
  assign cnt_inc = at_max ? MAX_V : cnt_q + ONE_V;

`ifdef PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] hcnt_inc;

  assign hcnt_inc = (hcnt_q == MAX_V) ? MAX_V : hcnt_q + ONE_V;
`else
  logic unused_level;
  assign unused_level = level;
`endif

  // A rise always wins over the timeout check, so a period of exactly MAX_CNT is still published.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
`ifdef PERIOD_METER_DUTY_EN
    hcnt_d   = hcnt_q;
    high_d   = high_q;
`endif
    case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_d   = ONE_V;
`ifdef PERIOD_METER_DUTY_EN
          hcnt_d  = ONE_V;
`endif
          state_d = MEAS;
        end else begin
          cnt_d = cnt_inc;
          if (at_max) state_d = TMO;
        end
      end
      MEAS: begin
        if (rise) begin
          period_d = cnt_q;
          valid_d  = 1'b1;
          cnt_d    = ONE_V;
`ifdef PERIOD_METER_DUTY_EN
          high_d   = hcnt_q;
          hcnt_d   = ONE_V;
`endif
        end else begin
          cnt_d = cnt_inc;
`ifdef PERIOD_METER_DUTY_EN
          if (level) hcnt_d = hcnt_inc;
`endif
          if (at_max) state_d = TMO;
        end
      end
      TMO: begin
        // The gap that ended here is not a period, so re-arm without publishing.
        if (rise) begin
          cnt_d   = ONE_V;
`ifdef PERIOD_METER_DUTY_EN
          hcnt_d  = ONE_V;
`endif
          state_d = MEAS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
`ifdef PERIOD_METER_DUTY_EN
      hcnt_q   <= '0;
      high_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
`ifdef PERIOD_METER_DUTY_EN
      hcnt_q   <= hcnt_d;
      high_q   <= high_d;
`endif
    end
  end

  assign period_o  = period_q;
  assign valid_o   = valid_q;
  assign timeout_o = (state_q == TMO);

`ifdef PERIOD_METER_DUTY_EN
  assign high_o = high_q;
`else
  assign high_o = '0;
`endif

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period and high time of a slow, free-running square wave, such as the 1 Hz divided clock our dividers produce, in units of `clk_i` cycles. It is the receiving end of the divided-clock interface: it synchronises the incoming waveform into the fast domain, detects rising edges and publishes one period/high-time sample per cycle of the input. It flags loss of signal with a timeout. Used for self-check of divider outputs and for display of measured frequency.

## Interface
- `CNT_W`, default 26: width of all counters and results.
- `MAX_CNT`, default 67108863 (2^26−1): largest measurable period; longer gaps raise timeout. Must satisfy 2 ≤ `MAX_CNT` ≤ 2^`CNT_W`−1.
- `clk_i`  in  1: system clock; all logic on its rising edge.
- `rst_ni`  in  1: synchronous, active-high reset.
- `sig_i`  in  1: measured waveform, asynchronous to `clk_i`.
- `period_o`  out  `CNT_W`: last measured period (rising edge to rising edge), in cycles.
- `high_o`  out  `CNT_W`: high time within that period, in cycles.
- `valid_o`  out  1: one-cycle pulse; `period_o`/`high_o` updated this cycle.
- `timeout_o`  out  1: level; no rising edge seen for `MAX_CNT` cycles.

## Operation
- Input path: 2-flop synchroniser (`s1`, `s2`), then a history flop `s3`. `rise = s2 & ~s3`.
- Counters: `cnt` (cycles since last rise) and `hcnt` (high cycles since last rise). Both saturate at `MAX_CNT` and never wrap.
- FSM states:
  - IDLE (reset state): wait for the first rise.
    - `cnt` increments.
    - On `rise`: `cnt←1`, `hcnt←1`, go to MEAS. No `valid_o`, because the first edge has no preceding period.
    - If `cnt==MAX_CNT` with no `rise`: go to TMO.
  - MEAS: `cnt` increments every cycle. `hcnt` increments while `s2==1`.
    - On `rise`: `period_o←cnt`, `high_o←hcnt`, `valid_o←1`, then `cnt←1`, `hcnt←1`, stay in MEAS.
    - If `cnt==MAX_CNT` and no `rise`: go to TMO.
  - TMO: `timeout_o=1`; counters hold.
    - On `rise`: `cnt←1`, `hcnt←1`, `timeout_o←0`, go to MEAS. No `valid_o`, because the gap is not a valid period.
- Simultaneous `rise` and `cnt==MAX_CNT`: the rise wins. `period_o=MAX_CNT` is published; no timeout.
- `period_o`/`high_o` hold their last value between updates and across timeout.
- Inputs faster than `clk_i`/2 are out of scope; the minimum reportable period is 2.

## Timing
- Reset values: `period_o=0`, `high_o=0`, `valid_o=0`, `timeout_o=0`, `s1..s3=0`, `cnt=0`, `hcnt=0`, state IDLE.
- Reset mid-measurement discards the partial period. The first rise after reset never produces `valid_o`.
- Latency: `sig_i` first sampled high at edge k gives `s1` at k, `s2` at k+1, and the `rise` cycle between k+1 and k+2. The outputs are registered at edge k+2, so `valid_o` is high for the cycle after k+2.
- `timeout_o` asserts exactly `MAX_CNT` cycles after the last rise is registered (`cnt` at 1). It deasserts on the registered rise.
- `valid_o` is never high on two consecutive cycles.

## Configuration
- `PERIOD_METER_DUTY_EN` defined: `hcnt` is implemented and `high_o` reports the high time.
- Not defined: `hcnt` is removed and `high_o` is tied to 0. Period and timeout behaviour are unchanged.

## Structure
- Package `period_meter_pkg`:
  - state enum `pm_state_e` {IDLE, MEAS, TMO};
  - default constants `PM_CNT_W=26` and `PM_MAX_CNT`.
- One sub-module, `sync_rise`: holds `s1`/`s2`/`s3` and outputs the synchronised level `s2` and `rise`. It has no parameters.
- FSM, counters and output registers live in `period_meter`.

## Test plan
All scenarios use `CNT_W=8`, `MAX_CNT=200`, with `PERIOD_METER_DUTY_EN` defined.

- Reset, then `sig_i` square wave with period 10 and 5 high: first rise gives no `valid_o`. Every following rise gives a `valid_o` pulse with `period_o=10`, `high_o=5`, spaced 10 cycles apart, 3 clocks after the `sig_i` edge.
- Period 10, high 3: `period_o=10`, `high_o=3`. Then toggle `sig_i` every cycle: `period_o=2`, `high_o=1`.
- Hold `sig_i` low for 250 cycles after a rise: `timeout_o=1` 200 cycles after the registered rise, and `period_o`/`high_o` keep their old values. Next rise: `timeout_o=0` with no `valid_o`. The following rise gives a valid sample.
- Period exactly 200 (high 100): `valid_o` with `period_o=200`, `high_o=100`, and `timeout_o` stays 0. Period 201: timeout asserts.
- Assert `rst_ni` for 1 cycle mid-period: all outputs are 0 on the next cycle. No `valid_o` until the second rise after reset.
- Build without `PERIOD_METER_DUTY_EN`, period 10 / high 5: `period_o=10`, `high_o=0`.
